// File: rtl/button_event_fsm_if.sv
// Button event bundle: debounced level in, registered event pulses and press counter out.
// master = event FSM side, slave = debounce source / event consumer side.
interface button_event_fsm_if;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  modport master (
    input  btn_level,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
  );

  modport slave (
    output btn_level,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
  );
endinterface

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into one-cycle press/release/long/repeat pulses and a press count.
// Optional macro AUTO_REPEAT_EN enables repeat_pulse generation while the button is held in LONG.
module button_event_fsm #(
  parameter int unsigned LONG_COUNT   = 3_000_000,
  parameter int unsigned REPEAT_COUNT = 1_000_000,
  parameter int          CNT_W        = 24
) (
  input  logic                clk,
  input  logic                reset,
  button_event_fsm_if.master  bus
);

  if (LONG_COUNT < 2 || REPEAT_COUNT < 2 ||
      64'(LONG_COUNT) > (64'd1 << CNT_W) || 64'(REPEAT_COUNT) > (64'd1 << CNT_W)) begin : g_bad_params
    $error("button_event_fsm: LONG_COUNT and REPEAT_COUNT must lie in 2..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_COUNT - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_COUNT - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t           state;
  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  assign rise = bus.btn_level & ~btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      btn_q             <= 1'b0;
      cnt               <= '0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
      bus.press_count   <= 8'd0;
    end else begin
      btn_q             <= bus.btn_level;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          // A level that was already high (no rise) never re-arms a press.
          if (rise) begin
            state           <= PRESSED;
            cnt             <= '0;
            bus.press_pulse <= 1'b1;
            bus.press_count <= bus.press_count + 8'd1;
            bus.held        <= 1'b1;
          end
        end

        PRESSED: begin
          if (!bus.btn_level) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else if (cnt == LONG_M1) begin
            state          <= LONG;
            cnt            <= '0;
            bus.long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LONG: begin
          // Release is tested first so it wins over a repeat due in the same cycle.
          if (!bus.btn_level) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (cnt == REP_M1) begin
              cnt              <= '0;
              bus.repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            cnt <= '0;
`endif
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm: expected pulses are queued per clock edge and checked every cycle.
module tb_button_event_fsm;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  button_event_fsm_if bus ();

  button_event_fsm #(
    .LONG_COUNT   (8),
    .REPEAT_COUNT (4),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Pulse vector order: {press, release, long, repeat}
  localparam logic [3:0] P    = 4'b1000;
  localparam logic [3:0] R    = 4'b0100;
  localparam logic [3:0] L    = 4'b0010;
  localparam logic [3:0] RP   = 4'b0001;
  localparam logic [3:0] NONE = 4'b0000;

  typedef struct {
    int         edge_id;
    logic [3:0] vec;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0] mon_obs;
  logic [3:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge; it is consumed by the next rising edge.
  task automatic drive(input logic lvl, input logic [3:0] v);
    @(negedge clk);
    bus.btn_level = lvl;
    if (v != NONE) q.push_back('{edge_n + 1, v});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_press"},   bus.press_pulse,   0);
    chk({tag, "_release"}, bus.release_pulse, 0);
    chk({tag, "_long"},    bus.long_pulse,    0);
    chk({tag, "_repeat"},  bus.repeat_pulse,  0);
    chk({tag, "_held"},    bus.held,          0);
    chk({tag, "_count"},   bus.press_count,   0);
  endtask

  always @(posedge clk) edge_n++;

  // Every cycle the pulse vector must match the queued entry for this edge, or be all zero.
  always @(negedge clk) begin
    mon_obs = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};
    mon_exp = NONE;
    if (q.size() > 0 && q[0].edge_id == edge_n) mon_exp = q.pop_front().vec;
    chk("pulses", mon_obs, mon_exp);
  end

  initial begin
    bus.btn_level = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    drive(0, NONE);
    drive(0, NONE);

    // Short press: press on first high sample, release on first low sample
    drive(1, P);
    drive(1, NONE);
    chk("t1_held_on", bus.held, 1);
    chk("t1_count", bus.press_count, 1);
    drive(1, NONE);
    drive(0, R);
    drive(0, NONE);
    chk("t1_held_off", bus.held, 0);
    chk("t1_count_after", bus.press_count, 1);

    // 20-sample hold: long at +8, repeats at +12/+16 only with auto-repeat, release wins at +20
    for (int i = 0; i < 20; i++) begin
      drive(1, (i == 0) ? P :
               (i == 8) ? L :
               (AUTO && (i == 12 || i == 16)) ? RP : NONE);
    end
    chk("t2_held_long", bus.held, 1);
    drive(0, R);
    drive(0, NONE);
    chk("t2_held_off", bus.held, 0);
    chk("t2_count", bus.press_count, 2);

    // Exactly 8 high samples: release replaces the long pulse
    drive(1, P);
    repeat (7) drive(1, NONE);
    drive(0, R);
    drive(0, NONE);
    chk("t4_held_off", bus.held, 0);
    chk("t4_count", bus.press_count, 3);
    drive(0, NONE);
    drive(1, P);
    drive(1, NONE);
    chk("t4_idle_repress", bus.held, 1);
    drive(0, R);
    drive(0, NONE);

    // Reset in LONG clears outputs without a clock edge and suppresses release
    drive(1, P);
    for (int i = 1; i < 10; i++) drive(1, (i == 8) ? L : NONE);
    chk("t6_held_before", bus.held, 1);
    chk("t6_long_before", bus.long_pulse, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    drive(1, NONE);
    drive(1, NONE);
    @(negedge clk);
    reset = 1'b1;
    bus.btn_level = 1'b1;
    q.push_back('{edge_n + 1, P});
    drive(0, R);
    chk("t6_count_after", bus.press_count, 1);
    drive(0, NONE);
    chk("t6_held_off", bus.held, 0);

    // 257 press/release pairs from a cleared counter: wraps 255 -> 0, ends at 1
    @(negedge clk);
    reset = 1'b0;
    bus.btn_level = 1'b0;
    #1;
    chk("t5_cleared", bus.press_count, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      drive(1, P);
      drive(0, R);
      chk("t5_count", bus.press_count, i % 256);
    end
    drive(0, NONE);
    chk("t5_final", bus.press_count, 1);

    repeat (3) drive(0, NONE);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
